// File: rtl/fpu_mac_feeder.sv
// fpu_mac_feeder: Avalon-MM master that clears the FPU MAC, streams A[i]/B[i]
// operand pairs from memory into MAC regs 0/1, then reads back the accumulated
// result and reports it with a one-cycle done pulse.
module fpu_mac_feeder #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned LEN_W    = 16,
  parameter int unsigned CLR_WAIT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_a,
  input  logic [ADDR_W-1:0] src_b,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic [31:0]       result,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_read,
  input  logic [31:0]       m_readdata,
  input  logic              m_waitrequest,
  output logic [2:0]        f_address,
  output logic [31:0]       f_writedata,
  output logic              f_write,
  output logic              f_read,
  input  logic [31:0]       f_readdata,
  input  logic              f_waitrequest
);

  localparam int unsigned CNT_W = (CLR_WAIT > 1) ? $clog2(CLR_WAIT) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_CLR, S_CWAIT, S_RD_A, S_RD_B, S_WR_A, S_WR_B, S_RD_RES, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [31:0]        result_q, result_d;
  logic [ADDR_W-1:0]  m_address_q, m_address_d;
  logic               m_read_q, m_read_d;
  logic [2:0]         f_address_q, f_address_d;
  logic [31:0]        f_writedata_q, f_writedata_d;
  logic               f_write_q, f_write_d;
  logic               f_read_q, f_read_d;
  logic [ADDR_W-1:0]  src_a_q, src_a_d;
  logic [ADDR_W-1:0]  src_b_q, src_b_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   index_q, index_d;
  logic [31:0]        op_a_q, op_a_d;
  logic [31:0]        op_b_q, op_b_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               m_acc;
  logic               f_wr_acc;
  logic               f_rd_acc;
  logic               launch;
  logic [LEN_W-1:0]   next_idx;

  // A transfer completes when the request is up and the slave is not stalling.
  assign m_acc    = m_read_q  && !m_waitrequest;
  assign f_wr_acc = f_write_q && !f_waitrequest;
  assign f_rd_acc = f_read_q  && !f_waitrequest;

  // Word address of element idx; wraps modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] elem_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [LEN_W-1:0]  idx);
    return base + ADDR_W'({idx, 2'b00});
  endfunction

  // Next-state and next-output logic; requests and payload are held while stalled.
  always_comb begin
    state_d       = state_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    result_d      = result_q;
    m_address_d   = m_address_q;
    m_read_d      = m_read_q;
    f_address_d   = f_address_q;
    f_writedata_d = f_writedata_q;
    f_write_d     = f_write_q;
    f_read_d      = f_read_q;
    src_a_d       = src_a_q;
    src_b_d       = src_b_q;
    len_d         = len_q;
    index_d       = index_q;
    op_a_d        = op_a_q;
    op_b_d        = op_b_q;
    cnt_d         = cnt_q;
    launch        = 1'b0;
    next_idx      = index_q + LEN_W'(1);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_a_d       = src_a;
          src_b_d       = src_b;
          len_d         = len;
          index_d       = '0;
          busy_d        = 1'b1;
          f_write_d     = 1'b1;
          f_address_d   = 3'd2;
          f_writedata_d = 32'd0;
          state_d       = S_CLR;
        end
      end
      S_CLR: begin
        if (f_wr_acc) begin
          f_write_d = 1'b0;
          cnt_d     = '0;
          if (CLR_WAIT == 0) launch = 1'b1;
          else               state_d = S_CWAIT;
        end
      end
      S_CWAIT: begin
        if (cnt_q == CNT_W'(CLR_WAIT - 1)) launch = 1'b1;
        else                               cnt_d  = cnt_q + CNT_W'(1);
      end
      S_RD_A: begin
        if (m_acc) begin
          op_a_d      = m_readdata;
          m_address_d = elem_addr(src_b_q, index_q);
          state_d     = S_RD_B;
        end
      end
      S_RD_B: begin
        if (m_acc) begin
          op_b_d        = m_readdata;
          m_read_d      = 1'b0;
          f_write_d     = 1'b1;
          f_address_d   = 3'd0;
          f_writedata_d = op_a_q;
          state_d       = S_WR_A;
        end
      end
      S_WR_A: begin
        if (f_wr_acc) begin
          f_address_d   = 3'd1;
          f_writedata_d = op_b_q;
          state_d       = S_WR_B;
        end
      end
      S_WR_B: begin
        if (f_wr_acc) begin
          f_write_d = 1'b0;
          index_d   = next_idx;
          if (next_idx == len_q) begin
            f_read_d    = 1'b1;
            f_address_d = 3'd0;
            state_d     = S_RD_RES;
          end else begin
            m_read_d    = 1'b1;
            m_address_d = elem_addr(src_a_q, next_idx);
            state_d     = S_RD_A;
          end
        end
      end
      S_RD_RES: begin
        if (f_rd_acc) begin
          f_read_d = 1'b0;
          result_d = f_readdata;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Leave the clear wait: fetch the first pair, or go straight to the result.
    if (launch) begin
      if (len_q != '0) begin
        m_read_d    = 1'b1;
        m_address_d = elem_addr(src_a_q, index_q);
        state_d     = S_RD_A;
      end else begin
        f_read_d    = 1'b1;
        f_address_d = 3'd0;
        state_d     = S_RD_RES;
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      result_q      <= '0;
      m_address_q   <= '0;
      m_read_q      <= 1'b0;
      f_address_q   <= '0;
      f_writedata_q <= '0;
      f_write_q     <= 1'b0;
      f_read_q      <= 1'b0;
      src_a_q       <= '0;
      src_b_q       <= '0;
      len_q         <= '0;
      index_q       <= '0;
      op_a_q        <= '0;
      op_b_q        <= '0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      result_q      <= result_d;
      m_address_q   <= m_address_d;
      m_read_q      <= m_read_d;
      f_address_q   <= f_address_d;
      f_writedata_q <= f_writedata_d;
      f_write_q     <= f_write_d;
      f_read_q      <= f_read_d;
      src_a_q       <= src_a_d;
      src_b_q       <= src_b_d;
      len_q         <= len_d;
      index_q       <= index_d;
      op_a_q        <= op_a_d;
      op_b_q        <= op_b_d;
      cnt_q         <= cnt_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = result_q;
  assign m_address   = m_address_q;
  assign m_read      = m_read_q;
  assign f_address   = f_address_q;
  assign f_writedata = f_writedata_q;
  assign f_write     = f_write_q;
  assign f_read      = f_read_q;

endmodule

// File: tb/tb_fpu_mac_feeder.sv
// Bench for fpu_mac_feeder: memory and MAC slaves modelled behaviourally,
// expected bus transactions and result derived from the job description.
module tb_fpu_mac_feeder;

  localparam int unsigned CW = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic [15:0] len = '0;
  logic        busy, done;
  logic [31:0] result;
  logic [31:0] m_address;
  logic        m_read;
  logic [31:0] m_readdata = '0;
  logic        m_waitrequest = 1'b0;
  logic [2:0]  f_address;
  logic [31:0] f_writedata;
  logic        f_write, f_read;
  logic [31:0] f_readdata = '0;
  logic        f_waitrequest = 1'b0;

  fpu_mac_feeder #(.ADDR_W(32), .LEN_W(16), .CLR_WAIT(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .src_a(src_a), .src_b(src_b), .len(len),
    .busy(busy), .done(done), .result(result),
    .m_address(m_address), .m_read(m_read), .m_readdata(m_readdata),
    .m_waitrequest(m_waitrequest),
    .f_address(f_address), .f_writedata(f_writedata), .f_write(f_write),
    .f_read(f_read), .f_readdata(f_readdata), .f_waitrequest(f_waitrequest)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  kind;   // 0 mem read, 1 MAC write, 2 MAC read, 3 none
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  int          errors = 0;
  int          checks = 0;
  txn_t        exp_q[$];
  logic [31:0] mlog[$];
  logic [31:0] exp_result = '0;
  logic [31:0] last_result = '0;
  logic [31:0] va[4];
  logic [31:0] vb[4];
  logic [31:0] base_a = '0;
  logic [31:0] base_b = '0;
  bit          job_active = 1'b0;
  bit          stall_en = 1'b0;
  bit          m_read_seen = 1'b0;
  int          n_b_acc = 0;
  real         acc = 0.0;
  logic [31:0] mac_a = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic real f32_to_real(input logic [31:0] b);
    real r;
    int  e;
    if (b[30:0] == 31'd0) return 0.0;
    r = 1.0 + real'(b[22:0]) / 8388608.0;
    e = int'(b[30:23]) - 127;
    while (e > 0) begin r = r * 2.0; e--; end
    while (e < 0) begin r = r / 2.0; e++; end
    return b[31] ? -r : r;
  endfunction

  function automatic logic [31:0] real_to_f32(input real v);
    real         r;
    int          e;
    logic        s;
    logic [22:0] m;
    if (v == 0.0) return 32'd0;
    s = (v < 0.0);
    r = s ? -v : v;
    e = 127;
    while (r >= 2.0) begin r = r / 2.0; e++; end
    while (r < 1.0)  begin r = r * 2.0; e--; end
    m = 23'($rtoi((r - 1.0) * 8388608.0));
    return {s, 8'(e), m};
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] addr);
    for (int i = 0; i < 4; i++) begin
      if (addr == base_a + 32'(4 * i)) return va[i];
      if (addr == base_b + 32'(4 * i)) return vb[i];
    end
    return 32'hDEADBEEF;
  endfunction

  // Slave models plus per-cycle comparison against the expected transaction list.
  txn_t obs, prev_obs, e_t;
  bit   prev_stall = 1'b0;
  bit   accept;
  int   nreq;
  always @(negedge clk) begin
    m_waitrequest = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
    f_waitrequest = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
    m_readdata    = mem_rd(m_address);
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      nreq = int'(m_read) + int'(f_write) + int'(f_read);
      obs.kind = m_read ? 2'd0 : f_write ? 2'd1 : f_read ? 2'd2 : 2'd3;
      obs.addr = m_read ? m_address : 32'(f_address);
      obs.data = f_write ? f_writedata : 32'd0;
      if (job_active) begin
        if (m_read) m_read_seen = 1'b1;
        chk("one_request", 128'(nreq <= 1), 128'd1);
        chk("busy", 128'(busy), done ? 128'd0 : 128'd1);
        if (prev_stall) chk("stall_hold", 128'(obs), 128'(prev_obs));
        if (done) begin
          chk("result", 128'(result), 128'(exp_result));
          chk("txn_left", 128'(exp_q.size()), 128'd0);
          last_result = result;
        end
        accept = (nreq == 1) && (m_read ? !m_waitrequest : !f_waitrequest);
        if (accept) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_txn: got %0h expected none", obs);
          end else begin
            e_t = exp_q.pop_front();
            chk("txn", 128'(obs), 128'(e_t));
          end
          if (m_read) mlog.push_back(m_address);
          if (f_write) begin
            case (f_address)
              3'd2: acc = 0.0;
              3'd0: mac_a = f_writedata;
              3'd1: begin
                acc = acc + f32_to_real(mac_a) * f32_to_real(f_writedata);
                n_b_acc++;
              end
              default: ;
            endcase
            f_readdata = real_to_f32(acc);
          end
        end
        prev_stall = (nreq == 1) && !accept;
        prev_obs   = obs;
      end else begin
        chk("idle_outputs", 128'({busy, done, m_read, f_write, f_read}), 128'd0);
        chk("result_hold", 128'(result), 128'(last_result));
        prev_stall = 1'b0;
      end
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, 128'(busy), 128'd0);
    chk({tag, "_done"}, 128'(done), 128'd0);
    chk({tag, "_reqs"}, 128'({m_read, f_write, f_read}), 128'd0);
    chk({tag, "_result"}, 128'(result), 128'd0);
    chk({tag, "_m_address"}, 128'(m_address), 128'd0);
    chk({tag, "_f_address"}, 128'(f_address), 128'd0);
    chk({tag, "_f_writedata"}, 128'(f_writedata), 128'd0);
  endtask

  // One job: build expectations, pulse start, wait (bounded) for done.
  task automatic run_job(input logic [31:0] a, input logic [31:0] b, input int n,
                         input bit stall, input int restart_at, input bit abort_b1,
                         output int lat);
    real sum;
    int  k;
    bit  aborted;
    base_a = a;
    base_b = b;
    exp_q.delete();
    mlog.delete();
    n_b_acc = 0;
    m_read_seen = 1'b0;
    aborted = 1'b0;
    lat = -1;
    sum = 0.0;
    exp_q.push_back('{kind: 2'd1, addr: 32'd2, data: 32'd0});
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{kind: 2'd0, addr: a + 32'(4 * i), data: 32'd0});
      exp_q.push_back('{kind: 2'd0, addr: b + 32'(4 * i), data: 32'd0});
      exp_q.push_back('{kind: 2'd1, addr: 32'd0, data: va[i]});
      exp_q.push_back('{kind: 2'd1, addr: 32'd1, data: vb[i]});
      sum = sum + f32_to_real(va[i]) * f32_to_real(vb[i]);
    end
    exp_q.push_back('{kind: 2'd2, addr: 32'd0, data: 32'd0});
    exp_result = real_to_f32(sum);

    @(posedge clk); #2;
    src_a = a; src_b = b; len = 16'(n); start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    src_a = 32'h5555_0000; src_b = 32'h6666_0000; len = 16'd7;
    job_active = 1'b1;
    stall_en = stall;
    k = 1;
    while (k < 400) begin
      if (done) begin lat = k + 1; break; end
      start = (k == restart_at);
      if (abort_b1 && f_write && f_address == 3'd1 && n_b_acc == 1) begin
        reset = 1'b1;
        start = 1'b0;
        job_active = 1'b0;
        stall_en = 1'b0;
        exp_q.delete();
        last_result = 32'd0;
        aborted = 1'b1;
        break;
      end
      @(posedge clk); #2;
      k++;
    end
    start = 1'b0;
    if (aborted) begin
      @(posedge clk); #2;
      chk_reset_vals("abort");
      reset = 1'b0;
    end else begin
      if (lat < 0) begin
        checks++;
        errors++;
        $display("FAIL done_timeout: got no done expected done within 400 cycles");
      end
      @(negedge clk); #1;
      job_active = 1'b0;
      stall_en = 1'b0;
    end
  endtask

  int lat;

  initial begin
    for (int i = 0; i < 4; i++) begin va[i] = '0; vb[i] = '0; end
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk_reset_vals("reset");
    reset = 1'b0;

    // T1: 2.0 * 3.0
    va[0] = 32'h40000000; vb[0] = 32'h40400000;
    run_job(32'h1000, 32'h2000, 1, 1'b0, -1, 1'b0, lat);
    chk("t1_result", 128'(result), 128'h40C00000);
    chk("t1_latency", 128'(lat), 128'd11);

    // T2: 1*2 + 3*4
    va[0] = 32'h3F800000; va[1] = 32'h40400000;
    vb[0] = 32'h40000000; vb[1] = 32'h40800000;
    run_job(32'h1000, 32'h2000, 2, 1'b0, -1, 1'b0, lat);
    chk("t2_result", 128'(result), 128'h41600000);
    chk("t2_latency", 128'(lat), 128'd15);
    chk("t2_nreads", 128'(mlog.size()), 128'd4);
    if (mlog.size() == 4) begin
      chk("t2_addr0", 128'(mlog[0]), 128'h1000);
      chk("t2_addr1", 128'(mlog[1]), 128'h2000);
      chk("t2_addr2", 128'(mlog[2]), 128'h1004);
      chk("t2_addr3", 128'(mlog[3]), 128'h2004);
    end

    // T3: T2 with random stalls on both masters
    run_job(32'h1000, 32'h2000, 2, 1'b1, -1, 1'b0, lat);
    chk("t3_result", 128'(result), 128'h41600000);
    chk("t3_nreads", 128'(mlog.size()), 128'd4);

    // T5: reset during WR_B of element 1 of 3, then the same job to completion
    va[0] = 32'h3F800000; va[1] = 32'h40000000; va[2] = 32'h40400000;
    vb[0] = 32'h3F800000; vb[1] = 32'h40000000; vb[2] = 32'h40400000;
    run_job(32'h1000, 32'h2000, 3, 1'b0, -1, 1'b1, lat);
    repeat (4) @(posedge clk);
    #2;
    run_job(32'h1000, 32'h2000, 3, 1'b0, -1, 1'b0, lat);
    chk("t5_result", 128'(result), 128'h41600000);
    chk("t5_latency", 128'(lat), 128'd19);

    // T4: empty job
    run_job(32'h3000, 32'h4000, 0, 1'b0, -1, 1'b0, lat);
    chk("t4_result", 128'(result), 128'h00000000);
    chk("t4_no_mread", 128'(m_read_seen), 128'd0);
    chk("t4_latency", 128'(lat), 128'd7);

    // start coinciding with reset is ignored
    @(posedge clk); #2;
    reset = 1'b1; start = 1'b1; last_result = 32'd0;
    @(posedge clk); #2;
    reset = 1'b0; start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("start_in_reset", 128'(busy), 128'd0);

    // T6: second start while busy, A base wraps past the top of memory
    va[0] = 32'h3F800000; va[1] = 32'h40000000;
    vb[0] = 32'h40A00000; vb[1] = 32'h40C00000;
    run_job(32'hFFFFFFFC, 32'h100, 2, 1'b0, 3, 1'b0, lat);
    chk("t6_result", 128'(result), 128'h41880000);
    chk("t6_latency", 128'(lat), 128'd15);
    chk("t6_nreads", 128'(mlog.size()), 128'd4);
    if (mlog.size() == 4) begin
      chk("t6_addr0", 128'(mlog[0]), 128'hFFFFFFFC);
      chk("t6_addr_wrap", 128'(mlog[2]), 128'h0);
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
